// File: rtl/alu_pkg.sv
// Shared types and decode constants for the EX-stage execute unit.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD   = 3'b000,
    OP_SUB   = 3'b001,
    OP_RTYPE = 3'b010,
    OP_AND   = 3'b011,
    OP_OR    = 3'b100,
    OP_XOR   = 3'b101,
    OP_LUI   = 3'b110,
    OP_SLT   = 3'b111
  } alu_op_e;

  typedef enum logic [3:0] {
    AC_AND  = 4'b0000,
    AC_OR   = 4'b0001,
    AC_ADD  = 4'b0010,
    AC_SLT  = 4'b0011,
    AC_SLTU = 4'b0100,
    AC_SUB  = 4'b0110,
    AC_XOR  = 4'b0111,
    AC_SLL  = 4'b1000,
    AC_SRL  = 4'b1001,
    AC_SRA  = 4'b1010,
    AC_LUI  = 4'b1011,
    AC_NOR  = 4'b1100
  } alu_ctrl_e;

  // Encoding matches funct[1:0] of the mult/multu/div/divu group.
  typedef enum logic [1:0] {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU} md_op_e;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_SIGN} md_state_e;

  typedef enum logic [2:0] {RS_ALU, RS_SRC_A, RS_HI, RS_LO, RS_ZERO} res_sel_e;

  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_SRA   = 6'b000011;
  localparam logic [5:0] F_SLLV  = 6'b000100;
  localparam logic [5:0] F_SRLV  = 6'b000110;
  localparam logic [5:0] F_SRAV  = 6'b000111;
  localparam logic [5:0] F_JR    = 6'b001000;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_ADDU  = 6'b100001;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SUBU  = 6'b100011;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;

endpackage

// File: rtl/alu_exec_unit_if.sv
// Issue/result bundle between the ID/EX register and the execute unit.
interface alu_exec_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
);
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [2:0]         alu_op;
  logic [5:0]         funct;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   src_a;
  logic [WIDTH-1:0]   src_b;
  logic               out_valid;
  logic [WIDTH-1:0]   result;
  logic               wb_en;
  logic               zero;
  logic               overflow;
  logic               illegal;
  logic               busy;

  modport master (
    output flush, in_valid, alu_op, funct, shamt, src_a, src_b,
    input  in_ready, out_valid, result, wb_en, zero, overflow, illegal, busy
  );

  modport slave (
    input  flush, in_valid, alu_op, funct, shamt, src_a, src_b,
    output in_ready, out_valid, result, wb_en, zero, overflow, illegal, busy
  );
endinterface

// File: rtl/alu_md_iter.sv
// Iterative mult/div engine: magnitude shift-add multiply, restoring divide, sign fix, HI/LO.
// state   | meaning
// ST_IDLE | waiting for start, HI/LO writable by mthi/mtlo
// ST_MUL  | one multiplier bit per cycle, WIDTH cycles
// ST_DIV  | one quotient bit per cycle, WIDTH cycles
// ST_SIGN | apply signs, commit HI/LO, signal done
module alu_md_iter
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             start,
  input  md_op_e           md_op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             hi_we,
  input  logic             lo_we,
  output logic             idle,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] lo_fin
);
  md_state_e          state_q, state_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]   wh_q, wh_d, wl_q, wl_d, mb_q, mb_d, a_q, a_d, hi_q, hi_d, lo_q, lo_d;
  logic               neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d, div_q, div_d;
  logic               sgn, is_div, a_neg, b_neg, ge;
  logic [WIDTH-1:0]   a_mag, b_mag, sdiff, hi_fin;
  logic [WIDTH:0]     msum, shifted;
  logic [2*WIDTH-1:0] prod_s;

  assign sgn     = (md_op == MD_MULT) || (md_op == MD_DIV);
  assign is_div  = (md_op == MD_DIV) || (md_op == MD_DIVU);
  assign a_neg   = sgn && src_a[WIDTH-1];
  assign b_neg   = sgn && src_b[WIDTH-1];
  assign a_mag   = a_neg ? -src_a : src_a;
  assign b_mag   = b_neg ? -src_b : src_b;
  assign msum    = {1'b0, wh_q} + (wl_q[0] ? {1'b0, mb_q} : '0);
  assign shifted = {wh_q, wl_q[WIDTH-1]};
  assign ge      = shifted >= {1'b0, mb_q};
  // remainder < divisor, so the true difference always fits in WIDTH bits
  assign sdiff   = shifted[WIDTH-1:0] - mb_q;
  assign prod_s  = neg_q ? -{wh_q, wl_q} : {wh_q, wl_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = (is_div && src_b == '0) ? ST_SIGN : (is_div ? ST_DIV : ST_MUL);
      ST_MUL, ST_DIV: begin
        if (flush)             state_d = ST_IDLE;
        else if (cnt_q == '0)  state_d = ST_SIGN;
      end
      ST_SIGN: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    idle = (state_q == ST_IDLE);
    done = (state_q == ST_SIGN) && !flush;
  end

  always_comb begin
    if (dz_q) begin
      hi_fin = a_q;
      lo_fin = '1;
    end else if (div_q) begin
      hi_fin = rneg_q ? -wh_q : wh_q;
      lo_fin = neg_q ? -wl_q : wl_q;
    end else begin
      hi_fin = prod_s[2*WIDTH-1:WIDTH];
      lo_fin = prod_s[WIDTH-1:0];
    end
  end

  always_comb begin
    cnt_d = cnt_q; wh_d = wh_q; wl_d = wl_q; mb_d = mb_q; a_d = a_q;
    neg_d = neg_q; rneg_d = rneg_q; dz_d = dz_q; div_d = div_q;
    hi_d = hi_q; lo_d = lo_q;
    case (state_q)
      ST_IDLE: if (start) begin
        cnt_d  = SHAMT_W'(WIDTH - 1);
        wh_d   = '0;
        wl_d   = is_div ? a_mag : b_mag;
        mb_d   = is_div ? b_mag : a_mag;
        neg_d  = a_neg ^ b_neg;
        rneg_d = a_neg;
        dz_d   = is_div && (src_b == '0);
        div_d  = is_div;
        a_d    = src_a;
      end
      ST_MUL: begin
        wh_d  = msum[WIDTH:1];
        wl_d  = {msum[0], wl_q[WIDTH-1:1]};
        cnt_d = cnt_q - SHAMT_W'(1);
      end
      ST_DIV: begin
        wh_d  = ge ? sdiff : shifted[WIDTH-1:0];
        wl_d  = {wl_q[WIDTH-2:0], ge};
        cnt_d = cnt_q - SHAMT_W'(1);
      end
      ST_SIGN: if (!flush) begin
        hi_d = hi_fin;
        lo_d = lo_fin;
      end
    endcase
    if (hi_we) hi_d = src_a;
    if (lo_we) lo_d = src_a;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0; wh_q <= '0; wl_q <= '0; mb_q <= '0; a_q <= '0;
      neg_q <= 1'b0; rneg_q <= 1'b0; dz_q <= 1'b0; div_q <= 1'b0;
      hi_q <= '0; lo_q <= '0;
    end else begin
      cnt_q <= cnt_d; wh_q <= wh_d; wl_q <= wl_d; mb_q <= mb_d; a_q <= a_d;
      neg_q <= neg_d; rneg_q <= rneg_d; dz_q <= dz_d; div_q <= div_d;
      hi_q <= hi_d; lo_q <= lo_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;
endmodule

// File: rtl/alu_exec_unit.sv
// EX-stage execute unit: decode, single-cycle ALU with registered result, and
// the iterative mult/div engine behind a valid/ready handshake.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input logic       clk,
  input logic       rst_n,
  alu_exec_if.slave io
);
  alu_ctrl_e          ctrl;
  res_sel_e           res_sel;
  logic               ovf_chk, wb, ill, md_req, mthi_req, mtlo_req;
  logic               accept, md_idle, md_done, alu_ovf;
  logic [SHAMT_W-1:0] sh;
  logic [WIDTH-1:0]   a, b, sum, diff, alu_res, res, hi, lo, lo_fin;
  logic [WIDTH-1:0]   result_d, result_q;
  logic               out_valid_d, out_valid_q, wb_en_d, wb_en_q, zero_d, zero_q;
  logic               overflow_d, overflow_q, illegal_d, illegal_q;

  assign a           = io.src_a;
  assign b           = io.src_b;
  assign sum         = a + b;
  assign diff        = a - b;
  assign io.in_ready = md_idle && !io.flush;
  assign accept      = io.in_valid && io.in_ready;

  always_comb begin
    ctrl = AC_ADD; res_sel = RS_ALU; ovf_chk = 1'b0; wb = 1'b1; ill = 1'b0;
    md_req = 1'b0; mthi_req = 1'b0; mtlo_req = 1'b0; sh = io.shamt;
    case (alu_op_e'(io.alu_op))
      OP_ADD:   ovf_chk = 1'b1;
      OP_SUB:   begin ctrl = AC_SUB; ovf_chk = 1'b1; end
      OP_AND:   ctrl = AC_AND;
      OP_OR:    ctrl = AC_OR;
      OP_XOR:   ctrl = AC_XOR;
      OP_LUI:   ctrl = AC_LUI;
      OP_SLT:   ctrl = AC_SLT;
      OP_RTYPE: begin
        case (io.funct)
          F_ADD:   ovf_chk = 1'b1;
          F_ADDU:  ctrl = AC_ADD;
          F_SUB:   begin ctrl = AC_SUB; ovf_chk = 1'b1; end
          F_SUBU:  ctrl = AC_SUB;
          F_AND:   ctrl = AC_AND;
          F_OR:    ctrl = AC_OR;
          F_XOR:   ctrl = AC_XOR;
          F_NOR:   ctrl = AC_NOR;
          F_SLT:   ctrl = AC_SLT;
          F_SLTU:  ctrl = AC_SLTU;
          F_SLL:   ctrl = AC_SLL;
          F_SRL:   ctrl = AC_SRL;
          F_SRA:   ctrl = AC_SRA;
          F_SLLV:  begin ctrl = AC_SLL; sh = a[SHAMT_W-1:0]; end
          F_SRLV:  begin ctrl = AC_SRL; sh = a[SHAMT_W-1:0]; end
          F_SRAV:  begin ctrl = AC_SRA; sh = a[SHAMT_W-1:0]; end
          F_JR:    begin res_sel = RS_SRC_A; wb = 1'b0; end
          F_MFHI:  res_sel = RS_HI;
          F_MFLO:  res_sel = RS_LO;
          F_MTHI:  begin res_sel = RS_SRC_A; wb = 1'b0; mthi_req = 1'b1; end
          F_MTLO:  begin res_sel = RS_SRC_A; wb = 1'b0; mtlo_req = 1'b1; end
          F_MULT, F_MULTU, F_DIV, F_DIVU: begin md_req = 1'b1; wb = 1'b0; end
          default: begin res_sel = RS_ZERO; wb = 1'b0; ill = 1'b1; end
        endcase
      end
    endcase
  end

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (ctrl)
      AC_AND:  alu_res = a & b;
      AC_OR:   alu_res = a | b;
      AC_XOR:  alu_res = a ^ b;
      AC_NOR:  alu_res = ~(a | b);
      AC_ADD:  begin alu_res = sum;  alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]); end
      AC_SUB:  begin alu_res = diff; alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]); end
      AC_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      AC_SLTU: alu_res = {{(WIDTH-1){1'b0}}, a < b};
      AC_SLL:  alu_res = b << sh;
      AC_SRL:  alu_res = b >> sh;
      AC_SRA:  alu_res = $signed(b) >>> sh;
      AC_LUI:  alu_res = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    res = alu_res;
    case (res_sel)
      RS_SRC_A: res = a;
      RS_HI:    res = hi;
      RS_LO:    res = lo;
      RS_ZERO:  res = '0;
      default:  res = alu_res;
    endcase
  end

  alu_md_iter #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) u_md (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (io.flush),
    .start  (accept && md_req),
    .md_op  (md_op_e'(io.funct[1:0])),
    .src_a  (a),
    .src_b  (b),
    .hi_we  (accept && mthi_req),
    .lo_we  (accept && mtlo_req),
    .idle   (md_idle),
    .done   (md_done),
    .hi     (hi),
    .lo     (lo),
    .lo_fin (lo_fin)
  );

  // mult/div completion reports the new LO but never writes back to the GPR file
  always_comb begin
    out_valid_d = 1'b0; wb_en_d = 1'b0; overflow_d = 1'b0; illegal_d = 1'b0;
    result_d = result_q; zero_d = zero_q;
    if (md_done) begin
      out_valid_d = 1'b1;
      result_d    = lo_fin;
      zero_d      = (lo_fin == '0);
    end else if (accept && !md_req) begin
      out_valid_d = 1'b1;
      result_d    = res;
      zero_d      = (res == '0);
      wb_en_d     = wb;
      overflow_d  = ovf_chk && alu_ovf;
      illegal_d   = ill;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0; result_q <= '0; wb_en_q <= 1'b0;
      zero_q <= 1'b0; overflow_q <= 1'b0; illegal_q <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d; result_q <= result_d; wb_en_q <= wb_en_d;
      zero_q <= zero_d; overflow_q <= overflow_d; illegal_q <= illegal_d;
    end
  end

  assign io.out_valid = out_valid_q;
  assign io.result    = result_q;
  assign io.wb_en     = wb_en_q;
  assign io.zero      = zero_q;
  assign io.overflow  = overflow_q;
  assign io.illegal   = illegal_q;
  assign io.busy      = !md_idle;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: directed ops push expectations, a monitor checks each out_valid.
module tb_alu_exec_unit;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_exec_if #(.WIDTH(32)) io ();
  alu_exec_unit #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .io(io));

  typedef struct {
    string       name;
    int          cyc;
    logic        ck;
    logic [31:0] res;
    logic        wb;
    logic        ovf;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%08h required 0x%08h", nm, act, req);
    end
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    if (rst_n && io.out_valid) begin
      exp_t e;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out_valid: got result 0x%08h at cycle %0d, required no output", io.result, cyc);
      end else begin
        e = sb.pop_front();
        chk({e.name, "_cycle"}, cyc, e.cyc);
        if (e.ck) begin
          chk({e.name, "_result"}, io.result, e.res);
          chk({e.name, "_zero"}, io.zero, (e.res == 32'h0));
        end
        chk({e.name, "_wb_en"}, io.wb_en, e.wb);
        chk({e.name, "_overflow"}, io.overflow, e.ovf);
        chk({e.name, "_illegal"}, io.illegal, e.ill);
      end
    end
  end

  // lat: extra edges after the accept edge before out_valid shows
  task automatic send(input string nm, input logic [2:0] op, input logic [5:0] fn,
                      input logic [4:0] sh, input logic [31:0] a, input logic [31:0] b,
                      input int lat, input logic push, input logic ck, input logic [31:0] res,
                      input logic wb, input logic ovf, input logic ill);
    int   n = 0;
    exp_t e;
    @(negedge clk);
    while (!io.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      total++;
      bad++;
      $display("FAIL %s_ready_timeout: in_ready 0 for %0d cycles, required 1", nm, n);
    end
    io.alu_op = op; io.funct = fn; io.shamt = sh; io.src_a = a; io.src_b = b;
    io.in_valid = 1'b1;
    if (push) begin
      e.name = nm; e.cyc = cyc + 1 + lat; e.ck = ck; e.res = res;
      e.wb = wb; e.ovf = ovf; e.ill = ill;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
  endtask

  initial begin
    io.flush = 1'b0; io.in_valid = 1'b0; io.alu_op = 3'b0; io.funct = 6'b0;
    io.shamt = 5'b0; io.src_a = 32'h0; io.src_b = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", io.out_valid, 0);
    chk("rst_result", io.result, 0);
    chk("rst_busy", io.busy, 0);
    chk("rst_wb_en", io.wb_en, 0);
    chk("rst_in_ready", io.in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    send("add_ovf",  3'b000, 6'h00,  0, 32'h7FFFFFFF, 32'h1, 0, 1, 1, 32'h80000000, 1, 1, 0);
    send("addu",     3'b010, F_ADDU, 0, 32'h7FFFFFFF, 32'h1, 0, 1, 1, 32'h80000000, 1, 0, 0);
    send("slt",      3'b010, F_SLT,  0, 32'hFFFFFFFF, 32'h1, 0, 1, 1, 32'h1, 1, 0, 0);
    send("sltu",     3'b010, F_SLTU, 0, 32'hFFFFFFFF, 32'h1, 0, 1, 1, 32'h0, 1, 0, 0);
    send("sra",      3'b010, F_SRA,  4, 32'h0, 32'h80000000, 0, 1, 1, 32'hF8000000, 1, 0, 0);
    send("lui",      3'b110, 6'h00,  0, 32'h0, 32'h1234, 0, 1, 1, 32'h12340000, 1, 0, 0);
    send("sub_ovf",  3'b010, F_SUB,  0, 32'h80000000, 32'h1, 0, 1, 1, 32'h7FFFFFFF, 1, 1, 0);
    send("srlv",     3'b010, F_SRLV, 0, 32'h4, 32'h80, 0, 1, 1, 32'h8, 1, 0, 0);
    send("nor",      3'b010, F_NOR,  0, 32'h0, 32'h0, 0, 1, 1, 32'hFFFFFFFF, 1, 0, 0);
    send("jr",       3'b010, F_JR,   0, 32'h1234, 32'h0, 0, 1, 1, 32'h1234, 0, 0, 0);
    send("add_zero", 3'b000, 6'h00,  0, 32'hFFFFFFFF, 32'h1, 0, 1, 1, 32'h0, 1, 0, 0);
    send("illegal",  3'b010, 6'h3F,  0, 32'h5, 32'h6, 0, 1, 1, 32'h0, 0, 0, 1);

    send("b2b_add",  3'b000, 6'h00,  0, 32'h5, 32'h3, 0, 1, 1, 32'h8, 1, 0, 0);
    send("b2b_sub",  3'b001, 6'h00,  0, 32'h5, 32'h3, 0, 1, 1, 32'h2, 1, 0, 0);
    send("b2b_and",  3'b011, 6'h00,  0, 32'hF0F0, 32'hFF00, 0, 1, 1, 32'hF000, 1, 0, 0);
    send("b2b_or",   3'b100, 6'h00,  0, 32'hF0, 32'h0F, 0, 1, 1, 32'hFF, 1, 0, 0);
    send("b2b_xor",  3'b101, 6'h00,  0, 32'hFF, 32'h0F, 0, 1, 1, 32'hF0, 1, 0, 0);

    send("mult",     3'b010, F_MULT, 0, 32'hFFFFFFFD, 32'h5, 33, 1, 0, 32'h0, 0, 0, 0);
    chk("mult_in_ready_low", io.in_ready, 0);
    chk("mult_busy", io.busy, 1);
    send("mult_lo",  3'b010, F_MFLO, 0, 32'h0, 32'h0, 0, 1, 1, 32'hFFFFFFF1, 1, 0, 0);
    send("mult_hi",  3'b010, F_MFHI, 0, 32'h0, 32'h0, 0, 1, 1, 32'hFFFFFFFF, 1, 0, 0);

    send("multu",    3'b010, F_MULTU, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 1, 0, 32'h0, 0, 0, 0);
    send("multu_lo", 3'b010, F_MFLO, 0, 32'h0, 32'h0, 0, 1, 1, 32'h1, 1, 0, 0);
    send("multu_hi", 3'b010, F_MFHI, 0, 32'h0, 32'h0, 0, 1, 1, 32'hFFFFFFFE, 1, 0, 0);

    send("div",      3'b010, F_DIV,  0, 32'hFFFFFFF9, 32'h2, 33, 1, 0, 32'h0, 0, 0, 0);
    send("div_lo",   3'b010, F_MFLO, 0, 32'h0, 32'h0, 0, 1, 1, 32'hFFFFFFFD, 1, 0, 0);
    send("div_hi",   3'b010, F_MFHI, 0, 32'h0, 32'h0, 0, 1, 1, 32'hFFFFFFFF, 1, 0, 0);

    send("divu_z",   3'b010, F_DIVU, 0, 32'h7, 32'h0, 1, 1, 0, 32'h0, 0, 0, 0);
    send("divu_z_lo", 3'b010, F_MFLO, 0, 32'h0, 32'h0, 0, 1, 1, 32'hFFFFFFFF, 1, 0, 0);
    send("divu_z_hi", 3'b010, F_MFHI, 0, 32'h0, 32'h0, 0, 1, 1, 32'h7, 1, 0, 0);

    send("div_min",  3'b010, F_DIV,  0, 32'h80000000, 32'hFFFFFFFF, 33, 1, 0, 32'h0, 0, 0, 0);
    send("div_min_lo", 3'b010, F_MFLO, 0, 32'h0, 32'h0, 0, 1, 1, 32'h80000000, 1, 0, 0);
    send("div_min_hi", 3'b010, F_MFHI, 0, 32'h0, 32'h0, 0, 1, 1, 32'h0, 1, 0, 0);

    send("mthi",     3'b010, F_MTHI, 0, 32'h1111, 32'h0, 0, 1, 0, 32'h0, 0, 0, 0);
    send("mtlo",     3'b010, F_MTLO, 0, 32'h2222, 32'h0, 0, 1, 0, 32'h0, 0, 0, 0);
    send("div_fl",   3'b010, F_DIV,  0, 32'd100, 32'd3, 0, 0, 0, 32'h0, 0, 0, 0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    io.flush = 1'b1;
    #1;
    chk("flush_in_ready_low", io.in_ready, 0);
    @(posedge clk);
    #1;
    io.flush = 1'b0;
    #1;
    chk("flush_busy_drop", io.busy, 0);
    chk("flush_in_ready", io.in_ready, 1);
    send("flush_hi", 3'b010, F_MFHI, 0, 32'h0, 32'h0, 0, 1, 1, 32'h1111, 1, 0, 0);
    send("flush_lo", 3'b010, F_MFLO, 0, 32'h0, 32'h0, 0, 1, 1, 32'h2222, 1, 0, 0);

    begin
      int n = 0;
      while (sb.size() != 0 && n < 200) begin
        @(posedge clk);
        n++;
      end
    end
    repeat (2) @(posedge clk);
    #2;
    chk("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
